uart_tx_io: RTL

UART_TX_IO -- requirements
Module: uart_tx_io

---
 rtl/io_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_io.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO blocks: register offsets,
// STATUS word layout and the UART transmitter state encoding.
package io_pkg;

  // Word register offsets (CPU address bits [3:2] within the IO window)
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS write bit that clears the sticky overflow flag
  localparam int unsigned STAT_OVF_CLR_BIT = 3;

  // Transmitter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int unsigned BAUD_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BITCNT_W = 3;
  localparam int unsigned STAT_CNT_W = 5;

  // STATUS register image; field order fixes the bit positions (busy = bit0)
  typedef struct packed {
    logic [22:0]           rsvd;
    logic [STAT_CNT_W-1:0] count;
    logic                  ovf;
    logic                  empty;
    logic                  full;
    logic                  busy;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: TXDATA pushes bytes into a small FIFO,
// STATUS reports busy/full/empty/overflow/count, and an 8N1 serialiser
// drains the FIFO back to back with no idle gap between frames.
module uart_tx_io
  import io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_wr,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wr_dat,
  output logic [31:0] rd_io_dat,
  output logic        uart_tx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0]          state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BITCNT_W-1:0] bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                ovf_q, ovf_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic [DATA_W-1:0]   fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                baud_done;
  logic                ovf_clr;
  logic                drop;
  logic                unused_wr_hi;
  status_t             status;

  assign fifo_push    = io_wr && (reg_sel == REG_TXDATA);
  assign ovf_clr      = io_wr && (reg_sel == REG_STATUS) && wr_dat[STAT_OVF_CLR_BIT];
  assign drop         = fifo_push && fifo_full && !fifo_pop;
  assign baud_done    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign unused_wr_hi = ^wr_dat[31:8];
  assign uart_tx      = tx_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_dat[DATA_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state, baud/bit timing, FIFO pop and registered line level
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BITCNT_W'(DATA_W - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + BITCNT_W'(1);
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
          end
        end
      end
      default: begin
        if (baud_done) begin
          baud_d = '0;
          bit_d  = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    // Line level follows the state being entered so it changes on the same edge
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    // A drop on the same edge as a clear leaves the flag set
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Register read mux; reads have no side effects
  always_comb begin
    status       = '0;
    status.busy  = (state_q != ST_IDLE);
    status.full  = fifo_full;
    status.empty = fifo_empty;
    status.ovf   = ovf_q;
    status.count = STAT_CNT_W'(fifo_count);
    rd_io_dat    = '0;
    if (reg_sel == REG_STATUS) rd_io_dat = status;
  end

endmodule
